// File: rtl/gcn_seq_engine_if.sv
// Job/result bundle for the sequential two-layer GCN engine.
// The master drives jobs and takes results; the slave is the engine.
interface gcn_seq_engine_if #(
  parameter int unsigned NODES   = 4,
  parameter int unsigned FEAT_IN = 4,
  parameter int unsigned HID     = 4,
  parameter int unsigned OUT     = 2,
  parameter int unsigned XW      = 5,
  parameter int unsigned WW      = 5
);
  localparam int unsigned XA_W  = XW + $clog2(NODES);
  localparam int unsigned H_W   = XA_W + WW + $clog2(FEAT_IN);
  localparam int unsigned HA_W  = H_W + $clog2(NODES);
  localparam int unsigned OUT_W = HA_W + WW + $clog2(HID);

  logic                          in_valid;
  logic                          in_ready;
  logic [NODES*NODES-1:0]        adj;
  logic [NODES*FEAT_IN*XW-1:0]   x_flat;
  logic [FEAT_IN*HID*WW-1:0]     w1_flat;
  logic [HID*OUT*WW-1:0]         w2_flat;
  logic                          out_valid;
  logic                          out_ready;
  logic [NODES*OUT*OUT_W-1:0]    out_flat;
  logic                          busy;

  modport master (
    output in_valid, adj, x_flat, w1_flat, w2_flat, out_ready,
    input  in_ready, out_valid, out_flat, busy
  );

  modport slave (
    input  in_valid, adj, x_flat, w1_flat, w2_flat, out_ready,
    output in_ready, out_valid, out_flat, busy
  );
endinterface

// File: rtl/gcn_seq_engine.sv
// Sequential two-layer GCN: aggregate features, dense+ReLU, aggregate hidden, dense.
// Each phase walks one node per cycle; all arithmetic is exact signed.
module gcn_seq_engine #(
  parameter int unsigned NODES   = 4,
  parameter int unsigned FEAT_IN = 4,
  parameter int unsigned HID     = 4,
  parameter int unsigned OUT     = 2,
  parameter int unsigned XW      = 5,
  parameter int unsigned WW      = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  gcn_seq_engine_if.slave bus
);
  localparam int unsigned XA_W  = XW + $clog2(NODES);
  localparam int unsigned H_W   = XA_W + WW + $clog2(FEAT_IN);
  localparam int unsigned HA_W  = H_W + $clog2(NODES);
  localparam int unsigned OUT_W = HA_W + WW + $clog2(HID);
  localparam int unsigned CntW  = $clog2(NODES);

  typedef enum logic [2:0] {StIdle, StAggx, StL1, StAggh, StL2, StDone} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                last_node;

  logic [NODES-1:0]         adj_q [NODES];
  logic signed [XW-1:0]     x_q   [NODES][FEAT_IN];
  logic signed [WW-1:0]     w1_q  [FEAT_IN][HID];
  logic signed [WW-1:0]     w2_q  [HID][OUT];
  logic signed [XA_W-1:0]   xa_q  [NODES][FEAT_IN];
  logic signed [H_W-1:0]    h_q   [NODES][HID];
  logic signed [HA_W-1:0]   ha_q  [NODES][HID];
  logic signed [OUT_W-1:0]  out_q [NODES][OUT];

  logic signed [XA_W-1:0]   xa_n  [FEAT_IN];
  logic signed [H_W-1:0]    h_n   [HID];
  logic signed [HA_W-1:0]   ha_n  [HID];
  logic signed [OUT_W-1:0]  out_n [OUT];
  logic signed [H_W-1:0]    h_acc;
  logic signed [OUT_W-1:0]  out_acc;

  assign last_node     = (cnt_q == CntW'(NODES - 1));
  assign bus.in_ready  = (state_q == StIdle) && rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

  // Per-node results for whichever phase is active; only the active one is latched.
  always_comb begin
    xa_n    = '{default: '0};
    h_n     = '{default: '0};
    ha_n    = '{default: '0};
    out_n   = '{default: '0};
    h_acc   = '0;
    out_acc = '0;
    for (int i = 0; i < FEAT_IN; i++) begin
      for (int j = 0; j < NODES; j++) begin
        if (adj_q[cnt_q][j]) xa_n[i] = xa_n[i] + XA_W'(x_q[j][i]);
      end
    end
    for (int k = 0; k < HID; k++) begin
      h_acc = '0;
      for (int i = 0; i < FEAT_IN; i++) begin
        h_acc = h_acc + H_W'(xa_q[cnt_q][i]) * H_W'(w1_q[i][k]);
      end
      h_n[k] = h_acc[H_W-1] ? '0 : h_acc;
      for (int j = 0; j < NODES; j++) begin
        if (adj_q[cnt_q][j]) ha_n[k] = ha_n[k] + HA_W'(h_q[j][k]);
      end
    end
    for (int m = 0; m < OUT; m++) begin
      out_acc = '0;
      for (int k = 0; k < HID; k++) begin
        out_acc = out_acc + OUT_W'(ha_q[cnt_q][k]) * OUT_W'(w2_q[k][m]);
      end
      out_n[m] = out_acc;
    end
  end

  always_comb begin
    bus.out_flat = '0;
    for (int n = 0; n < NODES; n++) begin
      for (int m = 0; m < OUT; m++) begin
        bus.out_flat[(n*OUT+m)*OUT_W +: OUT_W] = out_q[n][m];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      adj_q       <= '{default: '0};
      x_q         <= '{default: '0};
      w1_q        <= '{default: '0};
      w2_q        <= '{default: '0};
      xa_q        <= '{default: '0};
      h_q         <= '{default: '0};
      ha_q        <= '{default: '0};
      out_q       <= '{default: '0};
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            for (int n = 0; n < NODES; n++) begin
              adj_q[n] <= bus.adj[n*NODES +: NODES];
              for (int i = 0; i < FEAT_IN; i++) begin
                x_q[n][i] <= bus.x_flat[(n*FEAT_IN+i)*XW +: XW];
              end
            end
            for (int i = 0; i < FEAT_IN; i++) begin
              for (int k = 0; k < HID; k++) begin
                w1_q[i][k] <= bus.w1_flat[(k*FEAT_IN+i)*WW +: WW];
              end
            end
            for (int k = 0; k < HID; k++) begin
              for (int m = 0; m < OUT; m++) begin
                w2_q[k][m] <= bus.w2_flat[(m*HID+k)*WW +: WW];
              end
            end
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAggx;
          end
        end
        StAggx: begin
          xa_q[cnt_q] <= xa_n;
          cnt_q       <= last_node ? '0 : cnt_q + 1'b1;
          if (last_node) state_q <= StL1;
        end
        StL1: begin
          h_q[cnt_q] <= h_n;
          cnt_q      <= last_node ? '0 : cnt_q + 1'b1;
          if (last_node) state_q <= StAggh;
        end
        StAggh: begin
          ha_q[cnt_q] <= ha_n;
          cnt_q       <= last_node ? '0 : cnt_q + 1'b1;
          if (last_node) state_q <= StL2;
        end
        StL2: begin
          out_q[cnt_q] <= out_n;
          cnt_q        <= last_node ? '0 : cnt_q + 1'b1;
          if (last_node) state_q <= StDone;
        end
        StDone: begin
          // Valid is raised one cycle after entering DONE, then held until taken.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_gcn_seq_engine.sv
// Directed bench for gcn_seq_engine: latency, handshake hold, reset and arithmetic cases.
module tb_gcn_seq_engine;
  localparam int unsigned NODES   = 4;
  localparam int unsigned FEAT_IN = 4;
  localparam int unsigned HID     = 4;
  localparam int unsigned OUT     = 2;
  localparam int unsigned XW      = 5;
  localparam int unsigned WW      = 5;
  localparam int unsigned OUT_W   = XW + 2 + WW + 2 + 2 + WW + 2;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  gcn_seq_engine_if #(
    .NODES(NODES), .FEAT_IN(FEAT_IN), .HID(HID), .OUT(OUT), .XW(XW), .WW(WW)
  ) bus ();

  gcn_seq_engine #(
    .NODES(NODES), .FEAT_IN(FEAT_IN), .HID(HID), .OUT(OUT), .XW(XW), .WW(WW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] out_at(input int n, input int m);
    logic signed [OUT_W-1:0] v;
    v = bus.out_flat[(n*OUT+m)*OUT_W +: OUT_W];
    return {{(64-OUT_W){v[OUT_W-1]}}, v};
  endfunction

  task automatic fill(input logic [NODES*NODES-1:0] a, input int xv, input int w1v,
                      input int w2v);
    bus.adj = a;
    for (int n = 0; n < NODES*FEAT_IN; n++) bus.x_flat[n*XW +: XW] = XW'(xv);
    for (int n = 0; n < FEAT_IN*HID; n++) bus.w1_flat[n*WW +: WW] = WW'(w1v);
    for (int n = 0; n < HID*OUT; n++) bus.w2_flat[n*WW +: WW] = WW'(w2v);
  endtask

  // Accept the staged job, then scramble the buses so a leak into the job shows up.
  task automatic accept;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.adj      = '1;
    bus.x_flat   = '1;
    bus.w1_flat  = '1;
    bus.w2_flat  = '1;
    chk("acc_busy", bus.busy, 1);
    chk("acc_in_ready", bus.in_ready, 0);
  endtask

  task automatic wait_result;
    repeat (16) tick();
    chk("lat16_valid", bus.out_valid, 0);
    tick();
    chk("lat17_valid", bus.out_valid, 1);
  endtask

  task automatic check_node(input string tag, input int n, input int exp);
    for (int m = 0; m < OUT; m++) chk($sformatf("%s_n%0d_m%0d", tag, n, m), out_at(n, m), exp);
  endtask

  task automatic take_result;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("take_valid", bus.out_valid, 0);
    chk("take_in_ready", bus.in_ready, 1);
    chk("take_busy", bus.busy, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    fill('0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.out_valid, 0);
    check_node("rst_out", 0, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", bus.in_ready, 1);

    // Diamond graph, unit features and weights, then a held-off consumer.
    fill(16'hEDB7, 1, 1, 1);
    accept();
    wait_result();
    for (int n = 0; n < NODES; n++) check_node("diamond", n, 144);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_in_ready", bus.in_ready, 0);
      chk("hold_out", out_at(3, 1), 144);
    end
    take_result();
    check_node("retain", 2, 144);

    // Negative layer-1 weights: ReLU zeroes every hidden value.
    fill(16'hEDB7, 1, -1, 1);
    accept();
    wait_result();
    for (int n = 0; n < NODES; n++) check_node("relu", n, 0);
    take_result();

    // Extreme magnitudes on a fully connected graph.
    fill(16'hFFFF, -16, -16, 15);
    accept();
    wait_result();
    for (int n = 0; n < NODES; n++) check_node("extreme", n, 983040);
    take_result();

    // Identity graph, only node 2 carries features.
    fill(16'h8421, 0, 1, 2);
    for (int i = 0; i < FEAT_IN; i++) bus.x_flat[(2*FEAT_IN+i)*XW +: XW] = XW'(i + 1);
    accept();
    wait_result();
    check_node("ident", 0, 0);
    check_node("ident", 1, 0);
    check_node("ident", 2, 80);
    check_node("ident", 3, 0);
    take_result();

    // Diamond with node 3's row cleared.
    fill(16'h0DB7, 1, 1, 1);
    accept();
    wait_result();
    check_node("zrow", 0, 144);
    check_node("zrow", 1, 96);
    check_node("zrow", 2, 96);
    check_node("zrow", 3, 0);
    take_result();

    // Reset in the middle of layer 1, then a clean job.
    fill(16'hEDB7, 1, 1, 1);
    accept();
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    for (int n = 0; n < NODES; n++) check_node("mid_rst_out", n, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", bus.in_ready, 1);
    fill(16'hEDB7, 1, 1, 1);
    accept();
    wait_result();
    for (int n = 0; n < NODES; n++) check_node("after_rst", n, 144);
    take_result();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
